elem_frame_packer: RTL and testbench
====================================

ELEM_FRAME_PACKER -- requirements
Module: elem_frame_packer

Interface
REQ-001 SHALL have parameter J, default 3, meaning highest inner (column) index; columns per row = J+1.
REQ-002 SHALL have parameter K, default 2, meaning highest outer (row) index; rows per frame = K+1.
REQ-003 Local N = (K+1)*(J+1) elements per frame; W = 3*N frame bits (36 at defaults).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream element valid.
REQ-007 in_ready  output  1  packer accepts element this cycle.
REQ-008 in_elem  input  3  element {a,b,c}, a = bit 2, c = bit 0.
REQ-009 in_flush  input  1  discard partially filled frame.
REQ-010 out_valid  output  1  complete frame held on out_data.
REQ-011 out_ready  input  1  downstream consumes frame.
REQ-012 out_data  output  W  frame laid out as packed [K:0][J:0] of 3-bit elements; element [k][j] at bits 3*(k*(J+1)+j)+:3.
REQ-013 frame_cnt  output  8  count of frames delivered, wraps 255->0.

Function
REQ-014 States: FILL (collecting) and FULL (frame presented); handshake on a port = valid && ready in the same cycle.
REQ-015 In FILL: in_ready=1, out_valid=0.
REQ-016 Element index counter idx (0..N-1); accepted element i (0-based) written to slot N-1-i, so first element lands in [K][J], last in [0][0].
REQ-017 On acceptance with idx==N-1: transition to FULL next cycle, idx->0; out_valid=1 from the next cycle (one-cycle latency from last element).
REQ-018 In FULL: out_valid=1, out_data stable until handshake; in_ready=0 (see REQ-026 for exception).
REQ-019 Output handshake in FULL: next state FILL, frame_cnt increments by 1 mod 256.
REQ-020 Slots not yet written in the current frame SHALL read 0 (buffer cleared when a new frame starts).
REQ-021 in_flush in FILL: idx->0, buffer cleared, element presented in same cycle NOT accepted (in_ready forced 0 that cycle); flush has priority.
REQ-022 in_flush in FULL: ignored; a presented frame is never dropped.
REQ-023 out_ready without out_valid: no effect; in_valid while in_ready=0: no effect, element not consumed.
REQ-024 out_data in FILL: don't-care for consumers, but SHALL equal buffer contents (no X).

Reset
REQ-025 On rst=1 at a clock edge: state FILL, idx=0, buffer=0, out_valid=0, out_data=0, frame_cnt=0; in_ready=0 while rst high, 1 in first cycle after release; reset mid-frame discards partial and presented frames.

Configuration
REQ-026 Macro ELEM_FRAME_PACKER_OVERLAP_EN: when defined, in FULL in_ready=out_ready; a same-cycle output handshake and input handshake deliver the frame, clear buffer, store new element in slot N-1, idx->1, state FILL (zero-bubble, N cycles/frame sustained); when undefined, in_ready=0 in FULL and one bubble cycle per frame (N+1 cycles/frame sustained).

Verification
REQ-027 After reset, 12 elements 111,000,101,010,101,010,111,000,000,000,000,000 with out_ready=1 (no macro) -> out_valid one cycle after 12th, out_data=36'hE2AAB8000, frame_cnt 0->1 on handshake.
REQ-028 Same frame with out_ready=0 for 5 cycles -> out_valid held, out_data stable, in_ready=0, extra in_valid pulses ignored; release -> single handshake, state FILL.
REQ-029 Send 5 elements, assert in_flush with in_valid=1 -> that element dropped, then 12 fresh elements all 111 -> out_data=36'hFFFFFFFFF.
REQ-030 Back-to-back frames, in_valid and out_ready constantly 1: with ELEM_FRAME_PACKER_OVERLAP_EN -> one frame every 12 cycles; without -> every 13 cycles; data per frame correct.
REQ-031 Assert rst after 7 elements, and again while out_valid=1 -> all outputs zero next cycle, frame_cnt=0, next frame assembles from slot [K][J].
REQ-032 Deliver 256 frames -> frame_cnt wraps to 0; parameter run J=0,K=0 -> out_data equals each single element one cycle after acceptance.

Source files
------------

// File: rtl/elem_frame_packer.sv
// elem_frame_packer: packs a stream of 3-bit elements into a (K+1)x(J+1) frame.
// The first accepted element lands in slot [K][J], the last in [0][0]; the
// completed frame is held on out_data until the downstream handshake.
// Optional feature: define ELEM_FRAME_PACKER_OVERLAP_EN to let a new element
// be accepted in the same cycle the held frame is delivered (zero-bubble).
module elem_frame_packer #(
  parameter int J = 3,
  parameter int K = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_elem,
  input  logic                         in_flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3*(K+1)*(J+1)-1:0]     out_data,
  output logic [7:0]                   frame_cnt
);

  localparam int N  = (K + 1) * (J + 1);
  localparam int W  = 3 * N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic {
    FILL,
    FULL
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    buf_q, buf_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IW-1:0]   slot;
  logic            in_acc;
  logic            out_acc;

  // Element i of a frame goes to slot N-1-i so the first element is most significant.
  assign slot    = LAST - idx_q;
  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;

  assign out_data  = buf_q;
  assign frame_cnt = cnt_q;

  // State register: FSM state, element index, frame buffer and delivered-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: element capture, flush, frame completion and delivery.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    case (state_q)
      FILL: begin
        if (in_flush) begin
          idx_d = '0;
          buf_d = '0;
        end else if (in_acc) begin
          buf_d[3*slot +: 3] = in_elem;
          if (idx_q == LAST) begin
            state_d = FULL;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (out_acc) begin
          cnt_d   = cnt_q + 8'd1;
          buf_d   = '0;
          state_d = FILL;
          idx_d   = '0;
`ifdef ELEM_FRAME_PACKER_OVERLAP_EN
          // The new element starts the next frame in the freshly cleared buffer;
          // a single-element frame is immediately complete again.
          if (in_acc) begin
            buf_d[3*(N-1) +: 3] = in_elem;
            if (N == 1) begin
              state_d = FULL;
            end else begin
              idx_d = IW'(1);
            end
          end
`endif
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Output logic: handshake readiness/validity derived from state.
  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = 1'b0;
    if (!rst) begin
      case (state_q)
        FILL: in_ready = !in_flush;
`ifdef ELEM_FRAME_PACKER_OVERLAP_EN
        FULL: in_ready = out_ready;
`else
        FULL: in_ready = 1'b0;
`endif
        default: in_ready = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_elem_frame_packer.sv
// Self-checking bench for elem_frame_packer (default 4x3 instance plus a 1x1 instance).
module tb_elem_frame_packer;

  localparam int J = 3;
  localparam int K = 2;
  localparam int N = (K + 1) * (J + 1);
  localparam int W = 3 * N;
`ifdef ELEM_FRAME_PACKER_OVERLAP_EN
  localparam int PERIOD = N;
  localparam logic FULL_IN_READY = 1'b1;
`else
  localparam int PERIOD = N + 1;
  localparam logic FULL_IN_READY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   in_elem = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [7:0]   frame_cnt;

  logic         v1 = 1'b0;
  logic         or1 = 1'b0;
  logic         fl1 = 1'b0;
  logic [2:0]   e1 = '0;
  logic         ir1;
  logic         ov1;
  logic [2:0]   od1;
  logic [7:0]   fc1;

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;
  int exp_cnt = 0;

  logic [2:0] seq27 [12] = '{3'b111, 3'b000, 3'b101, 3'b010, 3'b101, 3'b010,
                             3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

  elem_frame_packer #(.J(J), .K(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_elem(in_elem), .in_flush(in_flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .frame_cnt(frame_cnt)
  );

  elem_frame_packer #(.J(0), .K(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1),
    .in_elem(e1), .in_flush(fl1), .out_valid(ov1),
    .out_ready(or1), .out_data(od1), .frame_cnt(fc1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] e);
    in_valid = 1'b1;
    in_elem  = e;
    step();
    in_valid = 1'b0;
  endtask

  task automatic flush();
    in_flush = 1'b1;
    step();
    in_flush = 1'b0;
  endtask

  // Reference: a frame is the accepted elements concatenated, first element most significant.
  task automatic stream(input int nframes, input bit rnd, input int budget);
    logic [W-1:0] cur = '0;
    int           cur_n = 0;
    logic [W-1:0] expq[$];
    int           last = -1;
    int           got = 0;
    int           cyc = 0;
    bit           acc;
    bit           del;
    while (got < nframes && cyc < budget) begin
      in_valid  = rnd ? ($urandom % 4 != 0) : 1'b1;
      in_elem   = 3'($urandom);
      out_ready = rnd ? ($urandom % 4 != 0) : 1'b1;
      #1;
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        if (expq.size() == 0) chk("stream_unexpected_frame", out_valid, 0);
        else chk("stream_data", out_data, expq.pop_front());
        if (!rnd && last >= 0) chk("stream_period", cyc - last, PERIOD);
        last = cyc;
        got++;
        exp_cnt++;
      end
      if (acc) begin
        cur = (cur << 3) | W'(in_elem);
        cur_n++;
        if (cur_n == N) begin
          expq.push_back(cur);
          cur   = '0;
          cur_n = 0;
        end
      end
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("stream_frames", got, nframes);
    chk("stream_cnt", frame_cnt, 8'(exp_cnt % 256));
  endtask

  initial begin
    logic [W-1:0] exp_f;
    logic [2:0]   e;

    // Reset state
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Known frame, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(seq27[i]);
    chk("f27_valid", out_valid, 1);
    chk("f27_data", out_data, 36'hE2AAB8000);
    chk("f27_cnt0", frame_cnt, 0);
    chk("f27_in_ready", in_ready, FULL_IN_READY);
    step();
    chk("f27_cnt1", frame_cnt, 1);
    chk("f27_after_valid", out_valid, 0);
    chk("f27_cleared", out_data, 0);

    // Backpressure: frame held, extra input ignored
    out_ready = 1'b0;
    exp_f = '0;
    for (int i = 0; i < 12; i++) begin
      e = 3'($urandom);
      exp_f = (exp_f << 3) | W'(e);
      send(e);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_elem  = 3'($urandom);
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, exp_f);
      chk("hold_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    chk("hold_data_end", out_data, exp_f);
    out_ready = 1'b1;
    step();
    chk("hs_cnt", frame_cnt, 2);
    chk("hs_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    step();
    chk("hs_single", frame_cnt, 2);

    // Flush drops the partial frame and the element presented with it
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(3'b111);
    chk("pre_flush_data", out_data, {15'h7FFF, 21'h0});
    in_flush = 1'b1;
    in_valid = 1'b1;
    in_elem  = 3'b111;
    #1;
    chk("flush_in_ready", in_ready, 0);
    step();
    in_flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_data", out_data, 0);
    chk("flush_valid", out_valid, 0);
    for (int i = 0; i < 11; i++) send(3'b111);
    chk("ones_not_yet", out_valid, 0);
    send(3'b111);
    chk("ones_valid", out_valid, 1);
    chk("ones_data", out_data, 36'hFFFFFFFFF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("ones_cnt", frame_cnt, 3);
    exp_cnt = 3;

    // Back-to-back throughput
    stream(4, 1'b0, 100);
    flush();

    // Random traffic across the 8-bit counter wrap
    stream(251, 1'b1, 20000);
    flush();

    // Reset mid-frame
    for (int i = 0; i < 7; i++) send(3'($urandom));
    rst = 1'b1;
    step();
    chk("r1_valid", out_valid, 0);
    chk("r1_data", out_data, 0);
    chk("r1_cnt", frame_cnt, 0);
    chk("r1_in_ready", in_ready, 0);
    rst = 1'b0;

    // Reset while a frame is presented
    for (int i = 0; i < 12; i++) send(3'($urandom_range(1, 7)));
    chk("r2_full", out_valid, 1);
    rst = 1'b1;
    step();
    chk("r2_valid", out_valid, 0);
    chk("r2_data", out_data, 0);
    chk("r2_cnt", frame_cnt, 0);
    rst = 1'b0;
    e = 3'($urandom_range(1, 7));
    send(e);
    chk("r3_first_slot", out_data, W'(e) << (3 * (N - 1)));
    chk("r3_valid", out_valid, 0);
    flush();

    // Single-element frames
    for (int i = 0; i < 6; i++) begin
      e  = 3'($urandom);
      e1 = e;
      v1 = 1'b1;
      step();
      v1 = 1'b0;
      chk("s_valid", ov1, 1);
      chk("s_data", od1, e);
      or1 = 1'b1;
      step();
      or1 = 1'b0;
      chk("s_done", ov1, 0);
    end
    chk("s_cnt", fc1, 6);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
